// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared data-memory bus.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requests and supplies memory read data.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic              a_err;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic              b_err;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] ReadData;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_err, b_rdata,
        output Address, WriteData, MemRead, MemWrite,
        input  ReadData
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_err, b_rdata,
        input  Address, WriteData, MemRead, MemWrite,
        output ReadData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared data memory.
// Port A is the CPU load/store unit and port B is the debug/DMA loader.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | wait for a request; latch the winner's id, we, addr, wdata
//   S_ACCESS | drive the memory strobes for one cycle; capture read data
//   S_ACK    | pulse the winner's ack (with err); record last grant
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              load;
    logic              pick_b;

    logic              last_b;
    logic              win_b;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              in_range;
    logic [DATA_W-1:0] rd_val;

    // The extra bit keeps the compare correct even when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
    assign rd_val   = in_range ? bus.ReadData : '0;

    // Next-state logic and arbitration: on a tie, the port not granted last wins.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pick_b     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    load       = 1'b1;
                    pick_b     = bus.b_req && (!bus.a_req || !last_b);
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: state_next = S_ACK;
            S_ACK:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched request, grant history and per-port read data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_b    <= 1'b1;
            win_b     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (load) begin
                win_b   <= pick_b;
                we_q    <= pick_b ? bus.b_we    : bus.a_we;
                addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
                wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
            end
            if (state == S_ACCESS && !we_q) begin
                if (win_b) begin
                    b_rdata_q <= rd_val;
                end else begin
                    a_rdata_q <= rd_val;
                end
            end
            if (state == S_ACK) begin
                last_b <= win_b;
            end
        end
    end

    // Memory side. The strobes are gated by reset so that a write sitting in
    // S_ACCESS when reset arrives never reaches the array.
    assign bus.Address   = addr_q;
    assign bus.WriteData = wdata_q;
    assign bus.MemWrite  = (state == S_ACCESS) &&  we_q && in_range && !reset;
    assign bus.MemRead   = (state == S_ACCESS) && !we_q && in_range && !reset;

    // Requester side. A transaction interrupted by reset is dropped without an ack.
    assign bus.a_ack   = (state == S_ACK) && !win_b && !reset;
    assign bus.b_ack   = (state == S_ACK) &&  win_b && !reset;
    assign bus.a_err   = bus.a_ack && !in_range;
    assign bus.b_err   = bus.b_ack && !in_range;
    assign bus.a_rdata = a_rdata_q;
    assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter. A high-level model predicts grant
// order, memory strobes and per-port ack results. The stimulus process pushes
// those predictions into queues, and a separate monitor pops and compares them
// whenever the DUT strobes memory or acks a port.
module tb_data_mem_arbiter;

    localparam int DEPTH = 32;

    typedef struct {
        int         port;
        logic       err;
        logic [7:0] rdata;
    } ack_t;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } strobe_t;

    logic clk;
    logic reset;

    data_mem_arbiter_if bus ();

    data_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory device (32x8, combinational read).
    logic [7:0] mem [0:DEPTH-1];
    assign bus.ReadData = (bus.Address < 8'(DEPTH)) ? mem[bus.Address[4:0]] : 8'h00;
    always @(posedge clk) begin
        if (bus.MemWrite && bus.Address < 8'(DEPTH)) mem[bus.Address[4:0]] <= bus.WriteData;
    end

    // Reference model state.
    logic [7:0] ref_mem [0:DEPTH-1];
    logic [7:0] held [0:1];
    int         last_grant;
    ack_t       ack_q[$];
    strobe_t    strobe_q[$];

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_grant = 1;
        held[0] = 8'h00;
        held[1] = 8'h00;
    endtask

    // Applies one granted access to the model in service order.
    task automatic predict(input int port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
        ack_t    a;
        strobe_t s;
        logic    inr;
        inr = (addr < 8'(DEPTH));
        if (inr) begin
            s.we = we; s.addr = addr; s.wdata = wdata;
            strobe_q.push_back(s);
            if (we) ref_mem[addr[4:0]] = wdata;
            else    held[port] = ref_mem[addr[4:0]];
        end else if (!we) begin
            held[port] = 8'h00;
        end
        a.port = port; a.err = !inr; a.rdata = held[port];
        ack_q.push_back(a);
        last_grant = port;
    endtask

    // Monitor: compares every strobe and every ack against the queued predictions.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.MemRead || bus.MemWrite) begin
                if (strobe_q.size() == 0) begin
                    chk("strobe_unexpected", 1, 0);
                end else begin
                    strobe_t s;
                    s = strobe_q.pop_front();
                    chk("strobe_memwrite", bus.MemWrite, s.we);
                    chk("strobe_memread", bus.MemRead, !s.we);
                    chk("strobe_addr", bus.Address, s.addr);
                    if (s.we) chk("strobe_wdata", bus.WriteData, s.wdata);
                end
            end
            if (bus.a_ack && bus.b_ack) begin
                chk("ack_both_ports", 1, 0);
            end else if (bus.a_ack || bus.b_ack) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 1, 0);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    chk("ack_port", bus.b_ack ? 1 : 0, a.port);
                    chk("ack_err", bus.b_ack ? bus.b_err : bus.a_err, a.err);
                    chk("ack_rdata", bus.b_ack ? bus.b_rdata : bus.a_rdata, a.rdata);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Port A performs na accesses and port B nb accesses, each holding req
    // continuously until its last ack. Starts and ends with the FSM idle.
    task automatic run_pair(input int na, input logic awe, input logic [7:0] aaddr,
                            input logic [7:0] awd, input int nb, input logic bwe,
                            input logic [7:0] baddr, input logic [7:0] bwd);
        int ra, rb, ca, cb, cyc, last_ack, budget;
        ra = na; rb = nb;
        while (ra > 0 || rb > 0) begin
            if (ra > 0 && (rb == 0 || last_grant == 1)) begin
                predict(0, awe, aaddr, awd); ra--;
            end else begin
                predict(1, bwe, baddr, bwd); rb--;
            end
        end
        bus.a_we = awe; bus.a_addr = aaddr; bus.a_wdata = awd; bus.a_req = (na > 0);
        bus.b_we = bwe; bus.b_addr = baddr; bus.b_wdata = bwd; bus.b_req = (nb > 0);
        ca = 0; cb = 0; cyc = 0; last_ack = -1;
        budget = 4 * (na + nb) + 8;
        while ((ca < na || cb < nb) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.a_ack || bus.b_ack) begin
                if (last_ack < 0) chk("ack_latency", cyc, 2);
                else              chk("ack_gap", cyc - last_ack, 3);
                last_ack = cyc;
            end
            if (bus.a_ack) begin ca++; if (ca >= na) bus.a_req = 1'b0; end
            if (bus.b_ack) begin cb++; if (cb >= nb) bus.b_req = 1'b0; end
        end
        if (ca < na || cb < nb) chk("ack_timeout", 1, 0);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'(i);
            ref_mem[i] = 8'(i);
        end
        mem[20] = 8'hFC;
        ref_mem[20] = 8'hFC;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;

        @(posedge clk);
        apply_reset();
        chk("rst_a_ack", bus.a_ack, 0);
        chk("rst_b_ack", bus.b_ack, 0);
        chk("rst_a_err", bus.a_err, 0);
        chk("rst_b_err", bus.b_err, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        chk("rst_b_rdata", bus.b_rdata, 0);
        chk("rst_address", bus.Address, 0);
        chk("rst_writedata", bus.WriteData, 0);
        chk("rst_strobes", {bus.MemRead, bus.MemWrite}, 0);

        // Directed scenarios.
        run_pair(1, 0, 8'd5, 8'h00, 0, 0, 8'd0, 8'h00);
        run_pair(0, 0, 8'd0, 8'h00, 1, 1, 8'd17, 8'hAA);
        run_pair(1, 0, 8'd17, 8'h00, 0, 0, 8'd0, 8'h00);
        apply_reset();
        run_pair(1, 0, 8'd3, 8'h00, 1, 0, 8'd20, 8'h00);
        run_pair(2, 0, 8'd3, 8'h00, 2, 0, 8'd20, 8'h00);
        apply_reset();
        run_pair(1, 1, 8'd40, 8'h55, 0, 0, 8'd0, 8'h00);
        run_pair(1, 0, 8'd8, 8'h00, 0, 0, 8'd0, 8'h00);

        // Reset arrives while a B write of 0x11 to addr 2 is in ACCESS.
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 8'd2; bus.b_wdata = 8'h11;
        @(posedge clk); #1;
        chk("pre_reset_memwrite", bus.MemWrite, 1);
        reset = 1'b1;
        bus.b_req = 1'b0;
        #1;
        chk("reset_memwrite", bus.MemWrite, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("reset_no_ack", bus.b_ack, 0);
        repeat (3) @(posedge clk);
        #1;
        run_pair(0, 0, 8'd0, 8'h00, 1, 0, 8'd2, 8'h00);

        // A holds req after ack: second access acked three cycles later.
        run_pair(2, 0, 8'd9, 8'h00, 0, 0, 8'd0, 8'h00);

        // Randomised rounds.
        for (int r = 0; r < 60; r++) begin
            int na, nb;
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            run_pair(na, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), 8'($urandom),
                     nb, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), 8'($urandom));
        end

        repeat (4) @(posedge clk);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("strobe_queue_drained", strobe_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the shared 32x8 data memory.
- Port A is the CPU load/store unit; port B is the debug/DMA loader.
- Serialises requests, drives the memory's Address/WriteData/MemRead/MemWrite, registers the memory's combinational read data and returns it with a one-cycle ack pulse.
- Round-robin priority; out-of-range addresses are rejected without touching memory.

Parameters:
- ADDR_W, 8, address width on requester and memory sides.
- DATA_W, 8, data width.
- DEPTH, 32, number of valid memory words; any address >= DEPTH is out of range.

Ports:
- clk  in  1  single system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle completion pulse for port A.
- a_err  out  1  valid with a_ack; 1 = out-of-range address.
- a_rdata  out  DATA_W  read data for port A, valid with a_ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: same as port A, for port B.
- Address  out  ADDR_W  memory address.
- WriteData  out  DATA_W  memory write data.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- ReadData  in  DATA_W  combinational memory read data.

Behaviour:
- Reset values: state=IDLE, last_grant=B (so A wins the first tie), all outputs 0 (acks, errs, rdata, Address, WriteData, MemRead, MemWrite).
- Reset mid-operation drops the transaction with no ack. A write already in ACCESS in that same cycle is suppressed, because reset has priority.
- FSM has three states:
  - IDLE: if no req, stay. Otherwise pick the winner: a sole requester wins; if both request, the port not in last_grant wins. Latch winner id, we, addr and wdata into internal registers, then go to ACCESS.
  - ACCESS: Address=latched addr; WriteData=latched wdata; MemWrite=we & in_range; MemRead=~we & in_range. Strobes are high for exactly this one cycle. Capture ReadData into the winner's rdata register if it is a read and in range. Go to ACK.
  - ACK: pulse the winner's ack for one cycle; err = ~in_range; last_grant = winner; go to IDLE.
- in_range = latched addr < DEPTH. Out-of-range accesses keep MemRead/MemWrite at 0 and return rdata=0 with err=1. An out-of-range write modifies nothing.
- Latency: req sampled high in IDLE at edge N gives strobes during cycle N+1 and ack during cycle N+2. Peak throughput is one access per 3 cycles.
- The loser's req stays pending and is served next, so starvation is impossible: with both requesting continuously, grants alternate A,B,A,B.
- Requester rule: deassert req in the cycle after ack. If req is still high when the FSM re-enters IDLE, it is taken as a new request.
- Requester inputs are ignored outside IDLE; only latched values drive memory.
- Outside ACCESS, Address and WriteData hold their last values and strobes are 0.
- rdata registers hold their value until the next read completes for that port. A write completion leaves rdata unchanged.
- A write in ACCESS followed by a read of the same address returns the new data, since memory updates at the end of ACCESS.

Test Plan:
- After reset, A reads addr 5 (a_req=1, a_we=0) -> MemRead high one cycle with Address=5; a_ack two cycles after sampling, a_rdata=0x05, a_err=0.
- B writes 0xAA to addr 17, then A reads 17 -> MemWrite one cycle with Address=17/WriteData=0xAA; b_ack; then a_rdata=0xAA.
- A and B both request reads of 3 and 20 in the same cycle right after reset -> A served first (rdata 0x03), then B (rdata 0xFC); with both held continuously, grants alternate A,B,A,B.
- A writes 0x55 to addr 40 -> MemWrite never asserts, a_ack with a_err=1 and a_rdata=0x00; a following read of addr 8 (40 mod 32) returns 0x08.
- Reset asserted during ACCESS of a B write of 0x11 to addr 2 -> MemWrite stays 0, no b_ack, FSM back in IDLE; reading addr 2 returns 0x02.
- Ack-then-hold: A keeps a_req high after a_ack -> a second access is issued and acked three cycles after the first.
